beam_scan_controller: RTL and testbench
=======================================

BEAM_SCAN_CONTROLLER -- requirements
Module: beam_scan_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock in Hz.
REQ-002 SHALL have parameter SAMPLING_RATE, default 1000000, ADC sample rate in Hz.
REQ-003 SHALL have parameter NUM_ANGLES, default 31, beam steps evenly spread over -90..+90 deg, odd and >= 3.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 64, clocks between an angle update and the start of a burst.
REQ-005 SHALL have parameter BURST_CYCLES, default 25000, transmit burst length in clocks.
REQ-006 SHALL have parameter LISTEN_SAMPLES, default 1024, sample ticks integrated per angle, power of 2.
REQ-007 SHALL have parameter SIN_WIDTH, default 17, sine magnitude width.
REQ-008 SHALL have port clk_in, input, 1, the single system clock.
REQ-009 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port start_in, input, 1, single-cycle sweep request.
REQ-011 SHALL have port stop_in, input, 1, abort request.
REQ-012 SHALL have port waveform_in, input, 16, beamformer aggregated output, unsigned, midscale 16'h8000.
REQ-013 SHALL have port sin_theta_out, output, SIN_WIDTH, |sin| of the current angle, fixed-point with full scale 2^(SIN_WIDTH-1).
REQ-014 SHALL have port sign_bit_out, output, 1, set when the current angle is < 0 deg.
REQ-015 SHALL have port sample_valid_out, output, 1, one-clock ADC/beamformer sample strobe.
REQ-016 SHALL have port tx_burst_out, output, 1, transmitter enable.
REQ-017 SHALL have port busy_out, output, 1, sweep in progress.
REQ-018 SHALL have port done_out, output, 1, one-clock pulse at sweep end.
REQ-019 SHALL have port peak_angle_out, output, $clog2(NUM_ANGLES), index of the highest-energy angle.
REQ-020 SHALL have port peak_energy_out, output, 16+$clog2(LISTEN_SAMPLES), energy at that angle.

Function
REQ-021 SHALL implement the FSM IDLE -> SETTLE -> BURST -> LISTEN -> COMPARE -> (SETTLE for the next angle | DONE) -> IDLE.
REQ-022 IDLE: start_in SHALL set angle index 0, clear peak_energy_out and peak_angle_out, and enter SETTLE on the next edge.
REQ-023 Angle index i SHALL map to angle (i - (NUM_ANGLES-1)/2) * 180/(NUM_ANGLES-1) deg; sin_theta_out and sign_bit_out SHALL be valid from the first SETTLE cycle and held through COMPARE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES clocks with all strobes low.
REQ-025 BURST: tx_burst_out SHALL be high for exactly BURST_CYCLES clocks, then the FSM SHALL enter LISTEN.
REQ-026 sample_valid_out SHALL pulse once every CLK_FREQ/SAMPLING_RATE clocks in BURST and LISTEN only; the divider SHALL restart at BURST entry.
REQ-027 LISTEN: on each sample_valid_out the block SHALL add |waveform_in - 16'h8000| (16-bit magnitude, 16'h8000 for 0) to the accumulator, sampling waveform_in one clock after the strobe; the accumulator SHALL clear at LISTEN entry and SHALL NOT saturate, being sized to hold the maximum sum.
REQ-028 LISTEN SHALL end after the LISTEN_SAMPLES-th accumulation; COMPARE SHALL last one clock and SHALL update the peak only on strictly greater energy, so the lowest index wins ties.
REQ-029 After COMPARE of index NUM_ANGLES-1 the block SHALL enter DONE, pulse done_out for one clock, and return to IDLE; otherwise it SHALL increment the index and enter SETTLE.
REQ-030 busy_out SHALL be high in every state except IDLE.
REQ-031 start_in while busy SHALL be ignored.
REQ-032 stop_in SHALL have priority over every other input: from any state it SHALL enter IDLE on the next edge with all strobes low and no done_out; the peak outputs SHALL keep their last values.

Reset
REQ-033 rst_in low SHALL asynchronously force IDLE, all strobes, busy_out and done_out to 0, the peak outputs to 0, sin_theta_out to 0 and sign_bit_out to 0; a reset during a sweep SHALL discard it.

Configuration
REQ-034 With SCAN_CONTINUOUS_EN defined, DONE SHALL pulse done_out and restart at index 0 (the SETTLE path of REQ-022) without returning to IDLE until stop_in; without it, the behaviour SHALL be as REQ-029.

Structure
REQ-035 A shared package beam_scan_pkg SHALL hold the FSM state enum, the default parameter constants and the midscale constant 16'h8000.
REQ-036 The sine table SHALL be a sub-module sin_angle_lut: a combinational ROM mapping |angle index offset| to |sin|, generated at elaboration.

Verification
REQ-037 The bench SHALL run NUM_ANGLES=3, SETTLE_CYCLES=4, BURST_CYCLES=8, LISTEN_SAMPLES=4, CLK_FREQ/SAMPLING_RATE=4, constant waveform_in=16'h8010: peak_energy_out SHALL be 64 and peak_angle_out 0; done_out SHALL pulse once.
REQ-038 The bench SHALL drive a waveform of 16'h9000 only when index 2 is active: peak_angle_out SHALL be 2, with sign_bit_out 1 at index 0 and sin_theta_out 65536 at indices 0 and 2.
REQ-039 The bench SHALL check that tx_burst_out is high for exactly 8 clocks and sample_valid_out fires every 4th clock from BURST entry.
REQ-040 The bench SHALL assert stop_in mid-LISTEN: the FSM SHALL be in IDLE next cycle, busy_out 0 and no done_out; start_in pulsed while busy SHALL have no effect.
REQ-041 The bench SHALL pulse rst_in low mid-BURST, asynchronously to the clock: all outputs SHALL be 0 immediately.
REQ-042 The bench SHALL run with SCAN_CONTINUOUS_EN defined: done_out SHALL pulse every sweep period and busy_out SHALL stay 1.

Source files
------------

// File: rtl/beam_scan_pkg.sv
// beam_scan_pkg: shared FSM states, default parameters, ADC midscale and the |sin| generator for the angle ROM.
package beam_scan_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, BURST, LISTEN, COMPARE, DONE} state_t;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_SAMPLING_RATE = 1_000_000;
  localparam int DEF_NUM_ANGLES = 31;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_BURST_CYCLES = 25_000;
  localparam int DEF_LISTEN_SAMPLES = 1024;
  localparam int DEF_SIN_WIDTH = 17;
  localparam logic [15:0] MIDSCALE = 16'h8000;
  localparam longint PI_HALF_Q30 = 64'sd1686629713;
  // Taylor series in Q30 for sin(k/half * pi/2), rounded to 2^(width-1) full scale; k == half is exact.
  function automatic longint sin_scaled(input int k, input int half, input int width);
    longint x, x2, term, sum;
    x = longint'(k) * PI_HALF_Q30 / longint'(half);
    x2 = (x * x) >>> 30;
    term = x;
    sum = x;
    for (int i = 1; i < 8; i++) begin
      term = -((term * x2) >>> 30) / longint'(2 * i * (2 * i + 1));
      sum += term;
    end
    return k >= half ? longint'(1) <<< (width - 1)
                     : (sum * (longint'(1) <<< (width - 1)) + (longint'(1) <<< 29)) >>> 30;
  endfunction
endpackage

// File: rtl/sin_angle_lut.sv
// sin_angle_lut: combinational ROM from |angle index offset| to |sin|, contents computed at elaboration.
module sin_angle_lut
  import beam_scan_pkg::*;
#(
  parameter int HALF = (DEF_NUM_ANGLES - 1) / 2,
  parameter int SIN_WIDTH = DEF_SIN_WIDTH
) (
  input  logic [$clog2(HALF+1)-1:0] ofs,
  output logic [SIN_WIDTH-1:0]      mag
);
  logic [SIN_WIDTH-1:0] rom [HALF+1];
  for (genvar k = 0; k <= HALF; k++) begin : g_rom
    localparam logic [SIN_WIDTH-1:0] V = SIN_WIDTH'(sin_scaled(k, HALF, SIN_WIDTH));
    assign rom[k] = V;
  end
  assign mag = rom[ofs];
endmodule

// File: rtl/beam_scan_controller.sv
// beam_scan_controller: settle/burst/listen sweep over beam angles, tracking the highest-energy angle.
// Define SCAN_CONTINUOUS_EN to restart the sweep after each DONE instead of returning to IDLE.
module beam_scan_controller
  import beam_scan_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int SAMPLING_RATE = DEF_SAMPLING_RATE,
  parameter int NUM_ANGLES = DEF_NUM_ANGLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int BURST_CYCLES = DEF_BURST_CYCLES,
  parameter int LISTEN_SAMPLES = DEF_LISTEN_SAMPLES,
  parameter int SIN_WIDTH = DEF_SIN_WIDTH
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start_in,
  input  logic                                  stop_in,
  input  logic [15:0]                           waveform_in,
  output logic [SIN_WIDTH-1:0]                  sin_theta_out,
  output logic                                  sign_bit_out,
  output logic                                  sample_valid_out,
  output logic                                  tx_burst_out,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic [$clog2(NUM_ANGLES)-1:0]         peak_angle_out,
  output logic [16+$clog2(LISTEN_SAMPLES)-1:0]  peak_energy_out
);
  localparam int AW = $clog2(NUM_ANGLES);
  localparam int HALF = (NUM_ANGLES - 1) / 2;
  localparam int OW = $clog2(HALF + 1);
  localparam int EW = 16 + $clog2(LISTEN_SAMPLES);
  localparam int DIV = CLK_FREQ / SAMPLING_RATE;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CMAX = BURST_CYCLES > SETTLE_CYCLES ? BURST_CYCLES : SETTLE_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int LW = LISTEN_SAMPLES > 1 ? $clog2(LISTEN_SAMPLES) : 1;
  state_t state, state_nx;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic [LW-1:0] n;
  logic [EW-1:0] acc;
  logic [15:0] mag;
  logic [OW-1:0] ofs;
  logic [SIN_WIDTH-1:0] sin_mag;
  logic sv_d, cnt_end, acc_en, acc_last, last_idx, sweep_start;
  sin_angle_lut #(.HALF(HALF), .SIN_WIDTH(SIN_WIDTH)) u_lut (.ofs(ofs), .mag(sin_mag));
  assign mag = waveform_in >= MIDSCALE ? waveform_in - MIDSCALE : MIDSCALE - waveform_in;
  assign ofs = OW'(idx >= AW'(HALF) ? idx - AW'(HALF) : AW'(HALF) - idx);
  assign cnt_end = cnt == CW'((state == SETTLE ? SETTLE_CYCLES : BURST_CYCLES) - 1);
  assign acc_en = sv_d && state == LISTEN;
  assign acc_last = acc_en && n == LW'(LISTEN_SAMPLES - 1);
  assign last_idx = idx == AW'(NUM_ANGLES - 1);
  assign sweep_start = state_nx == SETTLE && (state == IDLE || state == DONE);
  always_comb begin
    state_nx = state;
    tx_burst_out = state == BURST;
    sample_valid_out = (state == BURST || state == LISTEN) && div == DW'(DIV - 1);
    busy_out = state != IDLE;
    done_out = state == DONE;
    sin_theta_out = state == IDLE ? '0 : sin_mag;
    sign_bit_out = state != IDLE && idx < AW'(HALF);
    case (state)
      IDLE:    if (start_in) state_nx = SETTLE;
      SETTLE:  if (cnt_end) state_nx = BURST;
      BURST:   if (cnt_end) state_nx = LISTEN;
      LISTEN:  if (acc_last) state_nx = COMPARE;
      COMPARE: state_nx = last_idx ? DONE : SETTLE;
`ifdef SCAN_CONTINUOUS_EN
      DONE:    state_nx = SETTLE;
`else
      DONE:    state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
    if (stop_in) state_nx = IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      idx <= '0;
      cnt <= '0;
      div <= '0;
      n <= '0;
      acc <= '0;
      sv_d <= 1'b0;
      peak_angle_out <= '0;
      peak_energy_out <= '0;
    end else begin
      cnt <= state_nx != state ? '0 : cnt + 1'b1;
      div <= (state == BURST || state == LISTEN) && div != DW'(DIV - 1) ? div + 1'b1 : '0;
      // waveform_in is taken the clock after the strobe, so the strobe is delayed one cycle
      sv_d <= sample_valid_out && state == LISTEN;
      acc <= state == BURST ? '0 : acc_en ? acc + EW'(mag) : acc;
      n <= state == BURST ? '0 : acc_en ? n + 1'b1 : n;
      if (sweep_start) begin
        idx <= '0;
        peak_angle_out <= '0;
        peak_energy_out <= '0;
      end else if (state == COMPARE && !stop_in) begin
        if (acc > peak_energy_out) begin
          peak_energy_out <= acc;
          peak_angle_out <= idx;
        end
        if (!last_idx) idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_beam_scan_controller.sv
// tb_beam_scan_controller: scoreboard bench; expected angle and peak results are queued at stimulus and
// checked by a monitor on each burst entry and done pulse.
module tb_beam_scan_controller;
  typedef struct {int sin; int sign;} ang_t;
  typedef struct {int angle; int energy;} pk_t;
  logic clk, rst_n, start, stop, wmode;
  logic sign, sv, tx, busy, done;
  logic [15:0] waveform;
  logic [16:0] sin;
  logic [1:0] pk_angle;
  logic [17:0] pk_energy;
  int errs, checks, cyc, done_n, done_cyc, done_prev;
  ang_t ang_q[$];
  pk_t pk_q[$];

  beam_scan_controller #(
    .CLK_FREQ(4), .SAMPLING_RATE(1), .NUM_ANGLES(3), .SETTLE_CYCLES(4),
    .BURST_CYCLES(8), .LISTEN_SAMPLES(4), .SIN_WIDTH(17)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .stop_in(stop), .waveform_in(waveform),
    .sin_theta_out(sin), .sign_bit_out(sign), .sample_valid_out(sv), .tx_burst_out(tx),
    .busy_out(busy), .done_out(done), .peak_angle_out(pk_angle), .peak_energy_out(pk_energy)
  );

  // mode 1 raises the return only while the +90 deg beam (index 2) is selected
  assign waveform = !wmode ? 16'h8010 : (!sign && sin != '0) ? 16'h9000 : 16'h8000;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin cyc = 0; forever @(posedge clk) cyc++; end
  initial begin #200000; $display("FAIL watchdog: got no end by 200000 ns, want finish"); $fatal(1, "watchdog"); end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errs++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic check_zero(input string pre);
    chk({pre, "_tx"}, tx, 0);
    chk({pre, "_sv"}, sv, 0);
    chk({pre, "_busy"}, busy, 0);
    chk({pre, "_done"}, done, 0);
    chk({pre, "_sin"}, sin, 0);
    chk({pre, "_sign"}, sign, 0);
    chk({pre, "_peak_angle"}, pk_angle, 0);
    chk({pre, "_peak_energy"}, pk_energy, 0);
  endtask

  task automatic push_angles();
    ang_q.push_back('{65536, 1});
    ang_q.push_back('{0, 0});
    ang_q.push_back('{65536, 0});
  endtask

  task automatic kick(output int t0);
    start = 1;
    t0 = cyc;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_n < target; i++) @(negedge clk);
    if (done_n < target) fail("done_timeout", $sformatf("got %0d done pulses, want %0d", done_n, target));
  endtask

  task automatic sweep(input logic wm, input int pa, input int pe);
    int t0, d0;
    wmode = wm;
    push_angles();
    pk_q.push_back('{pa, pe});
    d0 = done_n;
    kick(t0);
    wait_cyc(t0 + 40);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(d0 + 1);
    chk("sweep_len", done_cyc - t0, 91);
    repeat (20) @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("done_once", done_n - d0, 1);
    chk("ang_q_drained", ang_q.size(), 0);
    chk("held_peak_angle", pk_angle, pa);
    chk("held_peak_energy", pk_energy, pe);
  endtask

  initial begin
    int p, tx_len;
    logic tx_q, in_b;
    ang_t a;
    pk_t k;
    p = 0;
    tx_len = 0;
    tx_q = 0;
    in_b = 0;
    forever begin
      @(negedge clk);
      if (!busy) in_b = 0;
      if (tx && !tx_q) begin
        p = 0;
        in_b = 1;
        if (ang_q.size() == 0) fail("unexpected_burst", "got a burst, want none pending");
        else begin
          a = ang_q.pop_front();
          chk("sin_theta", sin, a.sin);
          chk("sign_bit", sign, a.sign);
        end
      end else if (in_b) p++;
      if (in_b && p <= 25) chk($sformatf("sample_valid_p%0d", p), sv, p % 4 == 3);
      if (tx) tx_len++;
      else begin
        if (tx_q && busy) chk("tx_burst_len", tx_len, 8);
        tx_len = 0;
      end
      if (done) begin
        done_prev = done_cyc;
        done_cyc = cyc;
        done_n++;
        if (pk_q.size() == 0) fail("unexpected_done", "got done_out=1, want no sweep end");
        else begin
          k = pk_q.pop_front();
          chk("peak_angle", pk_angle, k.angle);
          chk("peak_energy", pk_energy, k.energy);
        end
      end
      tx_q = tx;
    end
  end

  initial begin
    int t0, d0;
    rst_n = 0;
    start = 0;
    stop = 0;
    wmode = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
`ifdef SCAN_CONTINUOUS_EN
    begin
      int low;
      wmode = 0;
      repeat (2) begin
        push_angles();
        pk_q.push_back('{0, 64});
      end
      d0 = done_n;
      low = 0;
      kick(t0);
      for (int i = 0; i < 400 && done_n < d0 + 2; i++) begin
        @(negedge clk);
        if (!busy) low++;
      end
      if (done_n < d0 + 2) fail("cont_done_timeout", $sformatf("got %0d done pulses, want 2", done_n - d0));
      chk("cont_busy_held_low_cycles", low, 0);
      chk("cont_first_done", done_prev - t0, 91);
      chk("cont_done_period", done_cyc - done_prev, 91);
      stop = 1;
      @(negedge clk);
      stop = 0;
      chk("cont_busy_after_stop", busy, 0);
      ang_q.delete();
      pk_q.delete();
    end
`else
    sweep(0, 0, 64);
    sweep(1, 2, 16384);
`endif
    wmode = 0;
    push_angles();
    d0 = done_n;
    kick(t0);
    wait_cyc(t0 + 45);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_cyc(t0 + 50);
    chk("listen_tx", tx, 0);
    chk("listen_busy", busy, 1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_tx", tx, 0);
    chk("stop_sv", sv, 0);
    chk("stop_done", done, 0);
    chk("stop_peak_angle", pk_angle, 0);
    chk("stop_peak_energy", pk_energy, 64);
    repeat (100) @(negedge clk);
    chk("stop_no_done", done_n - d0, 0);
    chk("stop_stays_idle", busy, 0);
    chk("stop_bursts_left", ang_q.size(), 1);
    ang_q.delete();
    push_angles();
    kick(t0);
    wait_cyc(t0 + 68);
    chk("pre_rst_tx", tx, 1);
    chk("pre_rst_sin", sin, 65536);
    chk("pre_rst_peak_energy", pk_energy, 64);
    #3 rst_n = 0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("rst_discards_sweep", busy, 0);
    chk("rst_bursts_left", ang_q.size(), 0);
    ang_q.delete();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
